// File: rtl/am_dds_mod_pipe.sv
// Pipelined DDS amplitude modulator: quarter-wave sine carrier times streamed message (DSB-SC, DSB-LC, carrier only).
// Optional phase dither (spreads truncation spurs) is enabled by defining AM_DDS_PHASE_DITHER_EN.
module am_dds_mod_pipe #(
   parameter int PHASE_W = 32,
   parameter int LUT_AW  = 6,
   parameter int C_W     = 16,
   parameter int MSG_W   = 16,
   parameter int OUT_W   = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [PHASE_W-1:0]      cfg_freq,
   input  logic [PHASE_W-1:0]      cfg_phase_off,
   input  logic                    cfg_phase_load,
   input  logic [1:0]              cfg_mode,
   input  logic [MSG_W-1:0]        cfg_carrier_lvl,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic signed [MSG_W-1:0] in_msg,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [OUT_W-1:0] out_data
);

   typedef enum logic [1:0] {
      MODE_DSB_SC  = 2'b00,
      MODE_DSB_LC  = 2'b01,
      MODE_CARRIER = 2'b10,
      MODE_RSVD    = 2'b11
   } mode_e;

   localparam int LUT_N   = 2 ** LUT_AW;
   localparam int TRUNC_W = PHASE_W - 2 - LUT_AW;
   localparam int S_W     = MSG_W + 1;
   localparam int P_W     = S_W + C_W;
   localparam int SH      = MSG_W + C_W - OUT_W - 1;

   localparam logic signed [MSG_W+1:0] S_MAX   = (MSG_W+2)'((1 << MSG_W) - 1);
   localparam logic signed [P_W-1:0]   RND     = P_W'(1) << (SH - 1);
   localparam logic signed [P_W-1:0]   OUT_MAX = (P_W'(1) << (OUT_W - 1)) - P_W'(1);
   localparam logic signed [P_W-1:0]   OUT_MIN = -OUT_MAX;

   // Quarter-wave table built at elaboration from a Taylor series (plain real arithmetic only).
   function automatic logic [LUT_N*C_W-1:0] build_rom();
      logic [LUT_N*C_W-1:0] tbl;
      real amp, x, term, acc;
      int  v;
      tbl = '0;
      amp = real'((longint'(1) << (C_W - 1)) - 1);
      for (int k = 0; k < LUT_N; k++) begin
         x    = 1.5707963267948966 * (real'(k) + 0.5) / real'(LUT_N);
         term = x;
         acc  = x;
         for (int n = 1; n < 10; n++) begin
            term = -term * x * x / real'((2 * n) * (2 * n + 1));
            acc  = acc + term;
         end
         v = $rtoi(amp * acc + 0.5);
         tbl[k*C_W +: C_W] = C_W'(v);
      end
      return tbl;
   endfunction

   localparam logic [LUT_N*C_W-1:0] ROM = build_rom();

   logic                    w_adv;
   logic                    w_accept;
   logic [1:0]              w_quad;
   logic [LUT_AW-1:0]       w_idx;
   logic [PHASE_W-1:0]      r_acc;

   // The whole pipeline moves as one: it advances whenever the output slot is free or being drained.
   assign w_adv    = out_ready | ~out_valid;
   assign in_ready = w_adv & ~rst;
   assign w_accept = in_valid & in_ready;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst)
         r_acc <= '0;
      else if (cfg_phase_load)
         r_acc <= cfg_phase_off;
      else if (w_accept)
         r_acc <= r_acc + cfg_freq;
   end

`ifdef AM_DDS_PHASE_DITHER_EN
   localparam int DITH_W = (TRUNC_W < 16) ? TRUNC_W : 16;

   logic [15:0]        r_lfsr;
   logic               w_lfsr_fb;
   logic [PHASE_W-1:0] w_phase_dith;
   logic               w_unused_trunc;

   assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

   always_ff @(posedge clk) begin
      if (rst)
         r_lfsr <= 16'hACE1;
      else if (w_accept)
         r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
   end

   assign w_phase_dith   = r_acc + PHASE_W'(r_lfsr[DITH_W-1:0]);
   assign w_quad         = w_phase_dith[PHASE_W-1 -: 2];
   assign w_idx          = w_phase_dith[PHASE_W-3 -: LUT_AW];
   assign w_unused_trunc = ^{w_phase_dith[TRUNC_W-1:0], r_lfsr};
`else
   assign w_quad = r_acc[PHASE_W-1 -: 2];
   assign w_idx  = r_acc[PHASE_W-3 -: LUT_AW];
`endif

   logic                    r_s1_valid;
   logic [1:0]              r_s1_quad;
   logic [LUT_AW-1:0]       r_s1_idx;
   logic signed [MSG_W-1:0] r_s1_msg;
   logic [MSG_W-1:0]        r_s1_lvl;
   mode_e                   r_s1_mode;

   logic                    r_s2_valid;
   logic signed [C_W-1:0]   r_s2_carrier;
   logic signed [MSG_W-1:0] r_s2_msg;
   logic [MSG_W-1:0]        r_s2_lvl;
   mode_e                   r_s2_mode;

   logic                    r_s3_valid;
   logic signed [P_W-1:0]   r_s3_prod;
   logic signed [C_W-1:0]   r_s3_carrier;
   mode_e                   r_s3_mode;

   logic                    r_out_valid;
   logic signed [OUT_W-1:0] r_out_data;

   logic [LUT_AW-1:0]       w_rom_addr;
   logic signed [C_W-1:0]   w_rom_val;
   logic signed [MSG_W+1:0] w_sum_wide;
   logic signed [S_W-1:0]   w_s;
   logic signed [P_W-1:0]   w_rnd;
   logic signed [P_W-1:0]   w_shifted;
   logic signed [OUT_W-1:0] w_s4_data;

   // Odd quadrants walk the table backwards; the lower half-cycle is the mirror image.
   assign w_rom_addr = r_s1_quad[0] ? ~r_s1_idx : r_s1_idx;
   assign w_rom_val  = ROM[int'(w_rom_addr)*C_W +: C_W];

   // The DC level only ever pushes the sum upward, so clipping the top keeps it in S_W bits.
   assign w_sum_wide = (MSG_W+2)'(r_s2_msg) + $signed({2'b00, r_s2_lvl});

   always_comb begin
      w_s = S_W'(r_s2_msg);
      if (r_s2_mode == MODE_DSB_LC)
         w_s = (w_sum_wide > S_MAX) ? S_W'(S_MAX) : S_W'(w_sum_wide);
   end

   assign w_rnd     = r_s3_prod + RND;
   assign w_shifted = w_rnd >>> SH;

   always_comb begin
      w_s4_data = '0;
      unique case (r_s3_mode)
         MODE_DSB_SC, MODE_DSB_LC: begin
            if (w_shifted > OUT_MAX)
               w_s4_data = OUT_W'(OUT_MAX);
            else if (w_shifted < OUT_MIN)
               w_s4_data = OUT_W'(OUT_MIN);
            else
               w_s4_data = OUT_W'(w_shifted);
         end
         MODE_CARRIER: w_s4_data = OUT_W'(r_s3_carrier >>> (C_W - OUT_W));
         default:      w_s4_data = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_valid   <= 1'b0;
         r_s1_quad    <= '0;
         r_s1_idx     <= '0;
         r_s1_msg     <= '0;
         r_s1_lvl     <= '0;
         r_s1_mode    <= MODE_DSB_SC;
         r_s2_valid   <= 1'b0;
         r_s2_carrier <= '0;
         r_s2_msg     <= '0;
         r_s2_lvl     <= '0;
         r_s2_mode    <= MODE_DSB_SC;
         r_s3_valid   <= 1'b0;
         r_s3_prod    <= '0;
         r_s3_carrier <= '0;
         r_s3_mode    <= MODE_DSB_SC;
         r_out_valid  <= 1'b0;
         r_out_data   <= '0;
      end else if (w_adv) begin
         r_s1_valid   <= w_accept;
         r_s1_quad    <= w_quad;
         r_s1_idx     <= w_idx;
         r_s1_msg     <= in_msg;
         r_s1_lvl     <= cfg_carrier_lvl;
         r_s1_mode    <= mode_e'(cfg_mode);

         r_s2_valid   <= r_s1_valid;
         r_s2_carrier <= r_s1_quad[1] ? -w_rom_val : w_rom_val;
         r_s2_msg     <= r_s1_msg;
         r_s2_lvl     <= r_s1_lvl;
         r_s2_mode    <= r_s1_mode;

         r_s3_valid   <= r_s2_valid;
         r_s3_prod    <= P_W'(w_s) * P_W'(r_s2_carrier);
         r_s3_carrier <= r_s2_carrier;
         r_s3_mode    <= r_s2_mode;

         r_out_valid  <= r_s3_valid;
         r_out_data   <= w_s4_data;
      end
   end

   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;

endmodule

// File: tb/tb_am_dds_mod_pipe.sv
// Self-checking bench for am_dds_mod_pipe: directed vector table, backpressure and reset sequences,
// and a randomized stream scored against a sine/arithmetic reference model.
module tb_am_dds_mod_pipe;

   localparam real PI = 3.14159265358979323846;

   logic               clk = 1'b0;
   logic               rst;
   logic [31:0]        cfg_freq;
   logic [31:0]        cfg_phase_off;
   logic               cfg_phase_load;
   logic [1:0]         cfg_mode;
   logic [15:0]        cfg_carrier_lvl;
   logic               in_valid;
   logic               in_ready;
   logic signed [15:0] in_msg;
   logic               out_valid;
   logic               out_ready;
   logic signed [15:0] out_data;

   always #5 clk = ~clk;

   am_dds_mod_pipe dut (
      .clk             (clk),
      .rst             (rst),
      .cfg_freq        (cfg_freq),
      .cfg_phase_off   (cfg_phase_off),
      .cfg_phase_load  (cfg_phase_load),
      .cfg_mode        (cfg_mode),
      .cfg_carrier_lvl (cfg_carrier_lvl),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .in_msg          (in_msg),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_data        (out_data)
   );

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input longint got, input longint exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s: got %0d, expected %0d", name, got, exp);
      end
   endtask

   // Reference model: ideal sampled sine, real-valued rounding and clipping.
   function automatic longint model_out(input logic [31:0] ph, input logic [1:0] mode,
                                        input logic signed [15:0] msg, input logic [15:0] lvl);
      int     q = int'(ph[31:30]);
      int     i = int'(ph[29:24]);
      int     k;
      longint c, s, o;
      k = (q % 2 == 1) ? 63 - i : i;
      c = longint'($rtoi(32767.0 * $sin(PI / 2.0 * (real'(k) + 0.5) / 64.0) + 0.5));
      if (q >= 2) c = -c;
      if (mode == 2'b10) return c;
      if (mode == 2'b11) return 0;
      s = msg;
      if (mode == 2'b01) begin
         s += lvl;
         if (s > 65535) s = 65535;
      end
      o = longint'($floor(real'(s * c) / 32768.0 + 0.5));
      if (o > 32767)  o = 32767;
      if (o < -32767) o = -32767;
      return o;
   endfunction

   logic [31:0] m_acc;
   longint      exp_q[$];
   bit          hs_seen;
   longint      last_out;
   int          n_acc = 0;
   int          n_out = 0;

   // One clock cycle: score this cycle's handshakes, then advance to the next falling edge.
   task automatic tick();
      longint e;
      #1;
      hs_seen = 1'b0;
      if (rst) begin
         m_acc = '0;
         exp_q.delete();
      end else begin
         if (out_valid && out_ready) begin
            hs_seen  = 1'b1;
            last_out = longint'(out_data);
            n_out++;
            check("out_expected", longint'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check("out_vs_model", last_out, e);
            end
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(model_out(m_acc, cfg_mode, in_msg, cfg_carrier_lvl));
            n_acc++;
         end
         if (cfg_phase_load) m_acc = cfg_phase_off;
         else if (in_valid && in_ready) m_acc = m_acc + cfg_freq;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   typedef struct {
      bit                 load;
      logic [31:0]        off;
      logic [31:0]        freq;
      logic [1:0]         mode;
      logic [15:0]        lvl;
      logic signed [15:0] msg;
      int                 exp;
   } vec_t;

   task automatic apply_one(input vec_t v, input string name, input bit chk_lat);
      int n0, lat;
      cfg_freq        = v.freq;
      cfg_mode        = v.mode;
      cfg_carrier_lvl = v.lvl;
      out_ready       = 1'b1;
      if (v.load) begin
         cfg_phase_off  = v.off;
         cfg_phase_load = 1'b1;
         tick();
         cfg_phase_load = 1'b0;
      end
      in_msg   = v.msg;
      in_valid = 1'b1;
      n0 = n_acc;
      tick();
      in_valid = 1'b0;
      check({name, "_accept"}, n_acc - n0, 1);
      lat = 0;
      do begin
         lat++;
         tick();
      end while (!hs_seen && lat < 20);
      check({name, "_arrived"}, longint'(hs_seen), 1);
      check(name, last_out, v.exp);
      if (chk_lat) check("latency", lat, 4);
   endtask

   vec_t vecs[12];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   initial begin
      int t, n0_acc, n0_out;
      logic signed [15:0] held;

      vecs[0]  = '{1'b0, 32'h0,         32'h4000_0000, 2'd0, 16'd0,     16'sd16384,  201};
      vecs[1]  = '{1'b0, 32'h0,         32'h4000_0000, 2'd0, 16'd0,     16'sd16384,  16383};
      vecs[2]  = '{1'b0, 32'h0,         32'h4000_0000, 2'd0, 16'd0,     16'sd16384,  -201};
      vecs[3]  = '{1'b0, 32'h0,         32'h4000_0000, 2'd0, 16'd0,     16'sd16384,  -16382};
      vecs[4]  = '{1'b0, 32'h0,         32'h4000_0000, 2'd2, 16'd0,     16'sd0,      402};
      vecs[5]  = '{1'b0, 32'h0,         32'h4000_0000, 2'd2, 16'd0,     16'sd0,      32765};
      vecs[6]  = '{1'b0, 32'h0,         32'h4000_0000, 2'd2, 16'd0,     16'sd0,      -402};
      vecs[7]  = '{1'b0, 32'h0,         32'h4000_0000, 2'd2, 16'd0,     16'sd0,      -32765};
      vecs[8]  = '{1'b1, 32'h4000_0000, 32'h4000_0000, 2'd1, 16'd32767, 16'sd32767,  32767};
      vecs[9]  = '{1'b1, 32'h4000_0000, 32'h4000_0000, 2'd1, 16'd32767, -16'sd32767, 0};
      vecs[10] = '{1'b1, 32'hC000_0000, 32'h4000_0000, 2'd2, 16'd0,     16'sd0,      -32765};
      vecs[11] = '{1'b0, 32'h0,         32'h4000_0000, 2'd2, 16'd0,     16'sd0,      402};

      rst = 1'b1; cfg_freq = '0; cfg_phase_off = '0; cfg_phase_load = 1'b0;
      cfg_mode = 2'd0; cfg_carrier_lvl = '0; in_valid = 1'b1; in_msg = 16'sd100; out_ready = 1'b1;
      @(negedge clk);
      tick();

      // Reset held with a sample offered
      for (int i = 0; i < 3; i++) begin
         #1;
         check("rst_in_ready", longint'(in_ready), 0);
         check("rst_out_valid", longint'(out_valid), 0);
         check("rst_out_data", longint'(out_data), 0);
         tick();
      end
      rst = 1'b0;
      in_valid = 1'b0;

      for (int i = 0; i < 12; i++)
         apply_one(vecs[i], $sformatf("vec%0d", i), i == 0);

      // Backpressure: 8 samples with a 5-cycle output stall mid-stream
      cfg_mode = 2'd0; cfg_freq = 32'h1234_5679; out_ready = 1'b1;
      n0_acc = n_acc; n0_out = n_out; t = 0; held = '0;
      while ((n_out - n0_out) < 8 && t < 100) begin
         in_valid  = (n_acc - n0_acc) < 8;
         in_msg    = 16'($urandom);
         out_ready = !(t >= 6 && t < 11);
         if (t >= 6 && t < 11) begin
            #1;
            check("bp_in_ready", longint'(in_ready), 0);
            check("bp_out_valid", longint'(out_valid), 1);
            if (t == 6) held = out_data;
            else check("bp_hold", longint'(out_data), longint'(held));
         end
         tick();
         t++;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      check("bp_count", n_out - n0_out, 8);
      check("bp_drained", exp_q.size(), 0);

      // Randomized stream with random backpressure and configuration
      n0_out = n_out;
      for (int i = 0; i < 500; i++) begin
         in_valid        = ($urandom_range(0, 3) != 0);
         out_ready       = ($urandom_range(0, 3) != 0);
         in_msg          = 16'($urandom);
         cfg_carrier_lvl = 16'($urandom);
         cfg_mode        = 2'($urandom);
         cfg_freq        = $urandom;
         cfg_phase_off   = $urandom;
         cfg_phase_load  = ($urandom_range(0, 15) == 0);
         tick();
      end
      in_valid = 1'b0; cfg_phase_load = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 20 && exp_q.size() > 0; i++) tick();
      check("rand_drained", exp_q.size(), 0);
      check("rand_outputs_seen", longint'((n_out - n0_out) > 100), 1);

      // Reset in the middle of a stream
      cfg_mode = 2'd2; cfg_freq = 32'h4000_0000; in_valid = 1'b1; out_ready = 1'b1;
      repeat (3) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      in_valid = 1'b0;
      #1;
      check("midrst_out_valid", longint'(out_valid), 0);
      check("midrst_queue", exp_q.size(), 0);
      apply_one('{1'b0, 32'h0, 32'h4000_0000, 2'd2, 16'd0, 16'sd0, 402}, "midrst_phase0", 1'b1);
      repeat (6) tick();
      check("final_drained", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
